// File: rtl/vga_arb_pkg.sv
// Shared types and default geometry for the video RAM arbiter.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  // Tag carried alongside an issued access so its read data can be routed back.
  typedef struct packed {
    grant_t src;
    logic   rd;
  } rd_tag_t;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_FIFO_DEPTH   = 8;
  localparam int unsigned DEF_LOW_WATER    = 2;
  localparam int unsigned DEF_FRAME_PIXELS = 307200;
  localparam int unsigned DEF_IMG0_BASE    = 0;
  localparam int unsigned DEF_IMG1_BASE    = 307200;

endpackage

// File: rtl/pixel_fifo.sv
// Pixel prefetch FIFO; when empty the output holds the last popped value.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] last_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign data    = empty ? last_q : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares the single-port video RAM between pixel prefetch and a CPU port.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned LOW_WATER    = DEF_LOW_WATER,
  parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int unsigned IMG0_BASE    = DEF_IMG0_BASE,
  parameter int unsigned IMG1_BASE    = DEF_IMG1_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              image_select,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underflow,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(IMG0_BASE);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(IMG1_BASE);
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(FRAME_PIXELS - 1);

  grant_t            grant_c;
  rd_tag_t           tag_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] frame_base;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic [OCC_W-1:0]  occ;
  logic              vga_inflight;
  logic              vga_elig;

  assign vga_inflight = (tag_q.src == GNT_VGA);
  assign occ          = OCC_W'(fifo_count) + OCC_W'(vga_inflight);
  assign vga_elig     = !fifo_full && (occ < OCC_W'(FIFO_DEPTH)) && !frame_start;

  // Starving pixel path preempts the CPU; otherwise the CPU takes priority.
  always_comb begin
    grant_c = GNT_NONE;
    if (!reset)                                   grant_c = GNT_NONE;
    else if (vga_elig && occ < OCC_W'(LOW_WATER)) grant_c = GNT_VGA;
    else if (cpu_valid)                           grant_c = GNT_CPU;
    else if (vga_elig)                            grant_c = GNT_VGA;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    unique case (grant_c)
      GNT_VGA: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant register doubles as the read-return tag for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '{src: GNT_NONE, rd: 1'b0};
    end else begin
      tag_q.src <= grant_c;
      tag_q.rd  <= (grant_c == GNT_VGA) || ((grant_c == GNT_CPU) && !cpu_we);
    end
  end

  assign cpu_rvalid = (tag_q.src == GNT_CPU) && tag_q.rd;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_base <= BASE0;
      fetch_addr <= BASE0;
    end else if (frame_start) begin
      frame_base <= image_select ? BASE1 : BASE0;
      fetch_addr <= image_select ? BASE1 : BASE0;
    end else if (grant_c == GNT_VGA) begin
      fetch_addr <= (fetch_addr == frame_base + LAST_OFS) ? frame_base
                                                          : fetch_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   underflow <= 1'b0;
    else if (frame_start)                         underflow <= 1'b0;
    else if (pix_pop && pix_empty)                underflow <= 1'b1;
  end

  // A VGA return landing on frame_start belongs to the old frame and is dropped.
  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (vga_inflight && !frame_start),
    .push_data (mem_rdata),
    .pop       (pix_pop),
    .data      (pix_data),
    .count     (fifo_count),
    .empty     (pix_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter with a behavioural RAM and frame model.
module tb_vga_mem_arbiter;

  localparam int unsigned FP    = 40;
  localparam int unsigned B0    = 0;
  localparam int unsigned B1    = 1000;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        image_select = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_pop = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_empty;
  logic        underflow;
  logic        cpu_valid = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  vga_mem_arbiter #(
    .ADDR_W(32), .DATA_W(8), .FIFO_DEPTH(DEPTH), .LOW_WATER(2),
    .FRAME_PIXELS(FP), .IMG0_BASE(B0), .IMG1_BASE(B1)
  ) dut (
    .clk(clk), .reset(reset), .image_select(image_select), .frame_start(frame_start),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_empty(pix_empty), .underflow(underflow),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen, required none", nm);
  endtask

  // Initial RAM content: a fixed hash of the address.
  function automatic logic [7:0] pat(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd13 + 32'd5;
    return t[7:0];
  endfunction

  // Behavioural RAM seen through the mem_* pins (sampled mid-cycle, applied at the edge).
  logic [7:0]  ram [int unsigned];
  logic        env_en = 1'b0, env_we = 1'b0;
  logic [31:0] env_addr = '0;
  logic [7:0]  env_wd = '0;

  always @(negedge clk) begin
    env_en   = mem_en & reset;
    env_we   = mem_we;
    env_addr = mem_addr;
    env_wd   = mem_wdata;
  end

  always @(posedge clk) begin
    if (env_en) begin
      if (env_we) ram[env_addr] = env_wd;
      else mem_rdata <= ram.exists(env_addr) ? ram[env_addr] : pat(env_addr);
    end
  end

  // Reference model: memory contents as the CPU has written them, frame walk pointers.
  logic [7:0]  shadow [int unsigned];
  logic [31:0] exp_fetch = B0, exp_fbase = B0, exp_pix = B0;
  logic [7:0]  last_pix = '0;

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [31:0] base);
    return (a == base + FP - 1) ? base : a + 1;
  endfunction

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  bit mon_en = 0, exp_data = 0, no_uf_chk = 0, full_chk = 0;
  int cyc = 0, cpu_acc = 0, pops = 0;

  // Monitor: checks every access, read return and pixel pop against the model.
  always @(negedge clk) begin
    cyc++;
    if (reset && mon_en) begin
      if (cpu_rvalid) begin
        if (exp_q.size() == 0) flag_fail("rvalid_spurious");
        else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          check("cpu_rdata", cpu_rdata, e.d);
          check("cpu_rd_latency", cyc, e.cyc + 1);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].cyc + 1 < cyc) begin
        void'(exp_q.pop_front());
        flag_fail("rvalid_missing");
      end
      if (mem_en) begin
        if (cpu_ready) begin
          check("cpu_addr_pass", mem_addr, cpu_addr);
          check("cpu_we_pass", mem_we, cpu_we);
          if (cpu_we) begin
            check("cpu_wdata_pass", mem_wdata, cpu_wdata);
            shadow[cpu_addr] = cpu_wdata;
          end else begin
            exp_q.push_back('{cyc: cyc, d: model_rd(cpu_addr)});
          end
          cpu_acc++;
        end else begin
          check("vga_addr", mem_addr, exp_fetch);
          check("vga_is_read", mem_we, 1'b0);
          if (frame_start) flag_fail("vga_on_frame_start");
          if (full_chk) flag_fail("vga_when_full");
          exp_fetch = nxt(exp_fetch, exp_fbase);
        end
      end
      if (pix_pop && !frame_start && exp_data) begin
        check("pix_nonempty", pix_empty, 1'b0);
        check("pix_data", pix_data, model_rd(exp_pix));
        last_pix = model_rd(exp_pix);
        exp_pix = nxt(exp_pix, exp_fbase);
        pops++;
      end
      if (frame_start) begin
        exp_fbase = image_select ? B1 : B0;
        exp_fetch = exp_fbase;
        exp_pix   = exp_fbase;
      end
      if (no_uf_chk) check("no_underflow", underflow, 1'b0);
    end
  end

  task automatic pop_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 pix_pop = 1'b1;
      @(posedge clk); #1 pix_pop = 1'b0;
    end
  endtask

  task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!cpu_ready) flag_fail("cpu_timeout");
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1 cpu_valid = 1'b0;
  endtask

  task automatic pulse_frame(input logic sel, input logic pop);
    @(posedge clk); #1 frame_start = 1'b1; image_select = sel; pix_pop = pop;
    @(posedge clk); #1 frame_start = 1'b0; pix_pop = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    int acc0, pop0;
    // Reset with requests asserted: nothing may reach memory.
    cpu_valid = 1'b1; pix_pop = 1'b1; cpu_addr = 32'h55;
    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_rvalid", cpu_rvalid, 1'b0);
    check("rst_empty", pix_empty, 1'b1);
    check("rst_underflow", underflow, 1'b0);
    check("rst_pix_data", pix_data, 8'h00);
    check("rst_mem_addr", mem_addr, 32'h0);
    cpu_valid = 1'b0; pix_pop = 1'b0;
    @(posedge clk); #1 reset = 1'b1; mon_en = 1;

    // Steady scan-out from image 0 with wrap (FP=40, 60 pixels).
    pulse_frame(1'b0, 1'b0);
    repeat (6) @(posedge clk);
    exp_data = 1; no_uf_chk = 1;
    pop_run(60);
    check("scan_pops", pops, 60);

    // CPU flood alongside scan-out.
    acc0 = cpu_acc; pop0 = pops;
    fork
      pop_run(40);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 9) < 3)
          cpu_issue(1'b1, 32'd4096 + 32'($urandom_range(0, 63)), 8'($urandom));
        else if ($urandom_range(0, 1) == 0)
          cpu_issue(1'b0, 32'd4096 + 32'($urandom_range(0, 63)), 8'h00);
        else
          cpu_issue(1'b0, 32'($urandom_range(0, 1039)), 8'h00);
      end
    join
    cpu_idle();
    check("flood_cpu_progress", cpu_acc - acc0, 60);
    check("flood_pix_progress", pops - pop0, 40);

    // FIFO full, no pops: memory idle, then a CPU write and read-back.
    repeat (14) @(posedge clk);
    full_chk = 1;
    repeat (4) @(negedge clk);
    check("full_idle_mem_en", mem_en, 1'b0);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 8'hAB;
    @(negedge clk);
    check("wr_ready", cpu_ready, 1'b1);
    check("wr_mem_en", mem_en, 1'b1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 8'hAB);
    cpu_issue(1'b0, 32'h10, 8'h00);
    cpu_idle();
    repeat (3) @(posedge clk);
    full_chk = 0;

    // Pop while empty right after a flush.
    no_uf_chk = 0; exp_data = 0;
    pulse_frame(1'b0, 1'b0);
    pix_pop = 1'b1;
    @(negedge clk);
    check("uf_empty", pix_empty, 1'b1);
    check("uf_pix_hold_pre", pix_data, last_pix);
    @(posedge clk); #1 pix_pop = 1'b0;
    @(negedge clk);
    check("underflow_set", underflow, 1'b1);
    check("uf_pix_hold", pix_data, last_pix);
    repeat (8) @(posedge clk);
    exp_data = 1;
    pop_run(10);
    check("underflow_sticky", underflow, 1'b1);

    // frame_start (with a pop) on top of an in-flight VGA read, switching to image 1.
    found = 0; n = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      if (mem_en && !cpu_ready) found = 1;
      n++;
    end
    if (!found) flag_fail("vga_issue_timeout");
    @(posedge clk); #1 frame_start = 1'b1; image_select = 1'b1; pix_pop = 1'b1;
    @(negedge clk);
    check("fs_no_vga", mem_en, 1'b0);
    @(posedge clk); #1 frame_start = 1'b0; pix_pop = 1'b0;
    @(negedge clk);
    check("fs_empty", pix_empty, 1'b1);
    check("fs_uf_clear", underflow, 1'b0);
    check("fs_pop_ignored", pix_data, last_pix);
    check("fs_next_addr_en", mem_en, 1'b1);
    check("fs_next_addr", mem_addr, B1);
    repeat (6) @(posedge clk);
    no_uf_chk = 1;
    pop_run(50);

    // Asynchronous reset in the middle of activity.
    @(posedge clk); #1 cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd4100;
    mon_en = 0;
    #3 reset = 1'b0;
    #1;
    check("midrst_mem_en", mem_en, 1'b0);
    check("midrst_ready", cpu_ready, 1'b0);
    check("midrst_empty", pix_empty, 1'b1);
    check("midrst_underflow", underflow, 1'b0);
    check("midrst_rvalid", cpu_rvalid, 1'b0);
    check("rd_queue_drained", exp_q.size(), 0);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
